// File: rtl/flit_injector_if.sv
// Packet-request, staging and credit-return bundle between a traffic source,
// the flit injector and the router injection port.
interface flit_injector_if #(
  parameter int VC_W  = 2,
  parameter int DST_W = 14,
  parameter int LEN_W = 8,
  parameter int TS_W  = 16
);
  logic                    pkt_valid;
  logic                    pkt_ready;
  logic [DST_W-1:0]        pkt_dst;
  logic [LEN_W-1:0]        pkt_len;
  logic [VC_W+DST_W+2:0]   out_staging;
  logic [VC_W+TS_W:0]      cr_staging;

  modport master (
    output pkt_valid, pkt_dst, pkt_len, cr_staging,
    input  pkt_ready, out_staging
  );

  modport slave (
    input  pkt_valid, pkt_dst, pkt_len, cr_staging,
    output pkt_ready, out_staging
  );
endinterface

// File: rtl/flit_injector.sv
// Credit-based flit source: segments packet requests into head/body/tail flits,
// allocates one VC per packet round-robin and tracks per-VC downstream credit.
module flit_injector #(
  parameter int NUM_VC    = 4,
  parameter int VC_W      = 2,
  parameter int BUF_DEPTH = 4,
  parameter int CRED_W    = 3,
  parameter int DST_W     = 14,
  parameter int LEN_W     = 8,
  parameter int TS_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  flit_injector_if.slave      bus,
  output logic                idle,
  output logic [31:0]         flits_sent,
  output logic                cr_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ALLOC = 2'd1, SEND = 2'd2} state_t;

  state_t                  state_r, state_s;
  logic [DST_W-1:0]        dst_r;
  logic [LEN_W-1:0]        rem_r;
  logic                    first_r;
  logic [VC_W-1:0]         cur_vc_r, rr_ptr_r;
  logic [CRED_W-1:0]       credit_r [NUM_VC];
  logic [CRED_W-1:0]       credit_s [NUM_VC];
  logic [VC_W+DST_W+2:0]   out_r;
  logic [31:0]             flits_r;
  logic                    cr_err_r, pkt_ready_r, idle_r;

  logic                    cr_valid_s, cr_vc_ok_s, cr_ovf_s;
  logic [VC_W-1:0]         cr_vc_s;
  logic                    unused_ts_s;
  logic [NUM_VC-1:0]       cr_inc_s, cr_dec_s;
  logic                    alloc_found_s, scan_hit_s;
  logic [VC_W-1:0]         alloc_vc_s;
  int                      scan_idx_s;
  logic                    send_s, tail_s;

  assign cr_valid_s  = bus.cr_staging[VC_W+TS_W];
  assign cr_vc_s     = bus.cr_staging[TS_W +: VC_W];
  assign unused_ts_s = ^bus.cr_staging[TS_W-1:0];
  assign cr_vc_ok_s  = ({{(32-VC_W){1'b0}}, cr_vc_s} < 32'(NUM_VC));

  assign send_s = (state_r == SEND) && (credit_r[cur_vc_r] != {CRED_W{1'b0}});
  assign tail_s = (rem_r == LEN_W'(1));

  // Round-robin scan for the first VC with credit, starting at rr_ptr.
  always_comb begin
    alloc_found_s = 1'b0;
    alloc_vc_s    = {VC_W{1'b0}};
    scan_idx_s    = 0;
    scan_hit_s    = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      scan_idx_s    = int'(rr_ptr_r) + i;
      scan_idx_s    = (scan_idx_s >= NUM_VC) ? scan_idx_s - NUM_VC : scan_idx_s;
      scan_hit_s    = !alloc_found_s && (credit_r[VC_W'(scan_idx_s)] != {CRED_W{1'b0}});
      alloc_vc_s    = scan_hit_s ? VC_W'(scan_idx_s) : alloc_vc_s;
      alloc_found_s = alloc_found_s | scan_hit_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = bus.pkt_valid ? ALLOC : IDLE;
      ALLOC:   state_s = alloc_found_s ? SEND : ALLOC;
      SEND:    state_s = (send_s && tail_s) ? IDLE : SEND;
      default: state_s = IDLE;
    endcase
  end

  // Per-VC credit update; a same-cycle return and send on one VC cancel out.
  always_comb begin
    cr_ovf_s = cr_valid_s && !cr_vc_ok_s;
    cr_inc_s = {NUM_VC{1'b0}};
    cr_dec_s = {NUM_VC{1'b0}};
    for (int v = 0; v < NUM_VC; v++) begin
      cr_inc_s[v] = cr_valid_s && cr_vc_ok_s && (cr_vc_s == VC_W'(v));
      cr_dec_s[v] = send_s && (cur_vc_r == VC_W'(v));
      credit_s[v] = credit_r[v];
      if (cr_inc_s[v] && !cr_dec_s[v]) begin
        if (credit_r[v] == CRED_W'(BUF_DEPTH)) begin
          cr_ovf_s = 1'b1;
        end else begin
          credit_s[v] = credit_r[v] + CRED_W'(1);
        end
      end else if (cr_dec_s[v] && !cr_inc_s[v]) begin
        credit_s[v] = credit_r[v] - CRED_W'(1);
      end else begin
        credit_s[v] = credit_r[v];
      end
    end
  end

  // State, packet context, credits and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      dst_r       <= {DST_W{1'b0}};
      rem_r       <= {LEN_W{1'b0}};
      first_r     <= 1'b0;
      cur_vc_r    <= {VC_W{1'b0}};
      rr_ptr_r    <= {VC_W{1'b0}};
      out_r       <= '0;
      flits_r     <= 32'd0;
      cr_err_r    <= 1'b0;
      pkt_ready_r <= 1'b1;
      idle_r      <= 1'b1;
      for (int v = 0; v < NUM_VC; v++) begin
        credit_r[v] <= CRED_W'(BUF_DEPTH);
      end
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (bus.pkt_valid) begin
            dst_r   <= bus.pkt_dst;
            rem_r   <= (bus.pkt_len == LEN_W'(0)) ? LEN_W'(1) : bus.pkt_len;
            first_r <= 1'b1;
          end
        end
        ALLOC: begin
          if (alloc_found_s) begin
            cur_vc_r <= alloc_vc_s;
          end
        end
        SEND: begin
          if (send_s) begin
            rem_r   <= rem_r - LEN_W'(1);
            first_r <= 1'b0;
            flits_r <= flits_r + 32'd1;
            if (tail_s) begin
              rr_ptr_r <= (cur_vc_r == VC_W'(NUM_VC - 1)) ? {VC_W{1'b0}} : cur_vc_r + VC_W'(1);
            end
          end
        end
        default: ;
      endcase
      out_r       <= send_s ? {1'b1, cur_vc_r, first_r, tail_s, dst_r} : '0;
      pkt_ready_r <= (state_s == IDLE);
      idle_r      <= (state_s == IDLE) && !send_s;
      cr_err_r    <= cr_err_r | cr_ovf_s;
      for (int v = 0; v < NUM_VC; v++) begin
        credit_r[v] <= credit_s[v];
      end
    end
  end

  assign bus.out_staging = out_r;
  assign bus.pkt_ready   = pkt_ready_r;
  assign idle            = idle_r;
  assign flits_sent      = flits_r;
  assign cr_err          = cr_err_r;

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector: reset, latency, credit stall/return,
// allocation skip, credit overflow and mid-packet reset.
module tb_flit_injector;
  localparam int OW = 1 + 2 + 2 + 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        idle, cr_err;
  logic [31:0] flits_sent;
  int          n_cmp = 0;
  int          n_bad = 0;

  flit_injector_if #(.VC_W(2), .DST_W(14), .LEN_W(8), .TS_W(16)) bus ();

  flit_injector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .idle       (idle),
    .flits_sent (flits_sent),
    .cr_err     (cr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] fl(input logic [1:0] vc, input logic h, input logic t,
                                       input logic [13:0] d);
    return {1'b1, vc, h, t, d};
  endfunction

  task automatic set_cr(input logic v, input logic [1:0] vc);
    bus.cr_staging = {v, vc, 16'hBEEF};
  endtask

  task automatic do_reset();
    bus.pkt_valid = 1'b0;
    set_cr(1'b0, 2'd0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Sends one packet assuming the chosen VC has enough credit; checks every flit.
  task automatic run_pkt(input logic [13:0] dst, input logic [7:0] len, input logic [1:0] vc);
    int n;
    n = (len == 8'd0) ? 1 : int'(len);
    chk("ready_idle", {31'd0, bus.pkt_ready}, 32'd1);
    bus.pkt_valid = 1'b1;
    bus.pkt_dst   = dst;
    bus.pkt_len   = len;
    tick();
    bus.pkt_valid = 1'b0;
    chk("ready_busy", {31'd0, bus.pkt_ready}, 32'd0);
    tick();
    chk("alloc_gap", 32'(bus.out_staging), 32'd0);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("flit", 32'(bus.out_staging), 32'(fl(vc, i == 0, i == n - 1, dst)));
    end
  endtask

  initial begin
    bus.pkt_valid = 1'b1;
    bus.pkt_dst   = 14'd12;
    bus.pkt_len   = 8'd4;
    set_cr(1'b0, 2'd0);
    @(negedge clk);
    tick();
    tick();
    chk("rst_ready", {31'd0, bus.pkt_ready}, 32'd1);
    chk("rst_out", 32'(bus.out_staging), 32'd0);
    chk("rst_flits", flits_sent, 32'd0);
    chk("rst_crerr", {31'd0, cr_err}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    rst_n = 1'b1;
    run_pkt(14'd12, 8'd4, 2'd0);
    chk("p4_flits", flits_sent, 32'd4);

    // Single-flit packets and len=0 handling
    do_reset();
    run_pkt(14'd12, 8'd1, 2'd0);
    chk("single_flits", flits_sent, 32'd1);
    chk("idle_during_tail", {31'd0, idle}, 32'd0);
    tick();
    chk("idle_after", {31'd0, idle}, 32'd1);
    chk("out_after", 32'(bus.out_staging), 32'd0);
    run_pkt(14'd5, 8'd0, 2'd1);
    chk("len0_flits", flits_sent, 32'd2);

    // Credit exhaustion and refill
    do_reset();
    bus.pkt_valid = 1'b1;
    bus.pkt_dst   = 14'd7;
    bus.pkt_len   = 8'd6;
    tick();
    bus.pkt_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("exh_flit", 32'(bus.out_staging), 32'(fl(2'd0, i == 0, 1'b0, 14'd7)));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("exh_stall", 32'(bus.out_staging), 32'd0);
    end
    chk("stall_idle", {31'd0, idle}, 32'd0);
    set_cr(1'b1, 2'd0);
    tick();
    chk("cr_latency", 32'(bus.out_staging), 32'd0);
    tick();
    set_cr(1'b0, 2'd0);
    chk("exh_flit5", 32'(bus.out_staging), 32'(fl(2'd0, 1'b0, 1'b0, 14'd7)));
    tick();
    chk("exh_flit6", 32'(bus.out_staging), 32'(fl(2'd0, 1'b0, 1'b1, 14'd7)));
    chk("exh_flits", flits_sent, 32'd6);

    // Simultaneous return and send on vc0
    do_reset();
    bus.pkt_valid = 1'b1;
    bus.pkt_dst   = 14'd3;
    bus.pkt_len   = 8'd8;
    tick();
    bus.pkt_valid = 1'b0;
    tick();
    tick();
    chk("sim_head", 32'(bus.out_staging), 32'(fl(2'd0, 1'b1, 1'b0, 14'd3)));
    chk("sim_cred_head", 32'(dut.credit_r[0]), 32'd3);
    set_cr(1'b1, 2'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("sim_flit", 32'(bus.out_staging), 32'(fl(2'd0, 1'b0, i == 7, 14'd3)));
    end
    chk("sim_cred_tail", 32'(dut.credit_r[0]), 32'd3);
    tick();
    set_cr(1'b0, 2'd0);
    chk("sim_cred_after", 32'(dut.credit_r[0]), 32'd4);
    chk("sim_crerr", {31'd0, cr_err}, 32'd0);
    chk("sim_flits", flits_sent, 32'd8);

    // Allocation skip: empty every VC, leave rr_ptr at 1
    do_reset();
    run_pkt(14'd1, 8'd1, 2'd0);
    run_pkt(14'd2, 8'd4, 2'd1);
    run_pkt(14'd3, 8'd4, 2'd2);
    run_pkt(14'd4, 8'd4, 2'd3);
    run_pkt(14'd5, 8'd3, 2'd0);
    set_cr(1'b1, 2'd2);
    tick();
    set_cr(1'b0, 2'd0);
    run_pkt(14'd9, 8'd1, 2'd2);
    bus.pkt_valid = 1'b1;
    bus.pkt_dst   = 14'd10;
    bus.pkt_len   = 8'd1;
    tick();
    bus.pkt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("alloc_wait", 32'(bus.out_staging), 32'd0);
      chk("alloc_ready", {31'd0, bus.pkt_ready}, 32'd0);
    end
    set_cr(1'b1, 2'd3);
    tick();
    set_cr(1'b0, 2'd0);
    chk("alloc_cr", 32'(bus.out_staging), 32'd0);
    tick();
    chk("alloc_pick", 32'(bus.out_staging), 32'd0);
    tick();
    chk("alloc_vc3", 32'(bus.out_staging), 32'(fl(2'd3, 1'b1, 1'b1, 14'd10)));

    // Overflow, then asynchronous reset mid-packet
    do_reset();
    set_cr(1'b1, 2'd2);
    tick();
    set_cr(1'b0, 2'd0);
    chk("ovf_crerr", {31'd0, cr_err}, 32'd1);
    chk("ovf_cred", 32'(dut.credit_r[2]), 32'd4);
    run_pkt(14'd11, 8'd1, 2'd0);
    chk("ovf_sticky", {31'd0, cr_err}, 32'd1);
    bus.pkt_valid = 1'b1;
    bus.pkt_dst   = 14'd20;
    bus.pkt_len   = 8'd5;
    tick();
    bus.pkt_valid = 1'b0;
    tick();
    tick();
    chk("mid_head", 32'(bus.out_staging), 32'(fl(2'd1, 1'b1, 1'b0, 14'd20)));
    tick();
    chk("mid_flit2", 32'(bus.out_staging), 32'(fl(2'd1, 1'b0, 1'b0, 14'd20)));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(bus.out_staging), 32'd0);
    chk("arst_crerr", {31'd0, cr_err}, 32'd0);
    chk("arst_flits", flits_sent, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_pkt(14'd21, 8'd2, 2'd0);
    chk("post_rst_flits", flits_sent, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
